// File: rtl/axis_loopback_tester.sv
// -----------------------------------------------------------------------------
// axis_loopback_tester
//
// AXI-Stream packet generator and checker for serdes loopback self-test.
// A run sends cfg_pkt_num packets of cfg_pkt_len bytes on the TX stream and
// checks the packets that come back on the RX stream. The run finishes once
// every packet has been sent and the same number of packets has been received.
//
// Payload: byte lane k of beat b of packet p = (p + b*KEEP_WIDTH + k) mod 256.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle run request, ignored while busy
//   cfg_pkt_num, cfg_pkt_len   packets per run / bytes per packet, latched at start
//   busy, done                 run in progress / run complete (held until next start)
//   tx_axis_*                  generator stream (tuser always 0)
//   rx_axis_*                  checker stream (tuser[0] = error flag)
//   tx_pkt_cnt, rx_pkt_cnt     saturating packet counters, cleared at start
//   err_cnt                    saturating count of errored RX beats, cleared at start
// -----------------------------------------------------------------------------
module axis_loopback_tester #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  cfg_pkt_num,
    input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
    output logic                  busy,
    output logic                  done,

    output logic                  tx_axis_tvalid,
    input  logic                  tx_axis_tready,
    output logic                  tx_axis_tlast,
    output logic [DATA_WIDTH-1:0] tx_axis_tdata,
    output logic [KEEP_WIDTH-1:0] tx_axis_tkeep,
    output logic [USER_WIDTH-1:0] tx_axis_tuser,

    input  logic                  rx_axis_tvalid,
    output logic                  rx_axis_tready,
    input  logic                  rx_axis_tlast,
    input  logic [DATA_WIDTH-1:0] rx_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] rx_axis_tkeep,
    input  logic [USER_WIDTH-1:0] rx_axis_tuser,

    output logic [CNT_WIDTH-1:0]  tx_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  rx_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    // Beat offset contribution to the payload, reduced mod 256 up front.
    localparam logic [7:0] KW_MOD = 8'(KEEP_WIDTH % 256);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_TX_DONE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;

    logic [CNT_WIDTH-1:0]   num_q;
    logic [LEN_WIDTH-1:0]   beats_q;
    logic [KEEP_WIDTH-1:0]  last_keep_q;
    logic [LEN_WIDTH-1:0]   tx_beat_q;
    logic [7:0]             rx_pkt_q;
    logic [LEN_WIDTH-1:0]   rx_beat_q;

    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [7:0]           pkt,
                                                        input logic [LEN_WIDTH-1:0] beat);
        logic [DATA_WIDTH-1:0] d;
        logic [7:0]            base;
        base = pkt + 8'(beat) * KW_MOD;
        d    = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            d[8*k +: 8] = base + 8'(k);
        end
        return d;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    // ------------------------------------------------------------------
    // Run control
    // ------------------------------------------------------------------
    logic start_ok;
    logic cfg_empty;
    logic tx_fire;
    logic tx_last;
    logic rx_fire;

    assign busy           = (state_q == S_SEND) || (state_q == S_TX_DONE);
    assign done           = (state_q == S_DONE);
    assign start_ok       = start && !busy;
    assign cfg_empty      = (cfg_pkt_num == '0) || (cfg_pkt_len == '0);
    assign tx_axis_tvalid = (state_q == S_SEND);
    assign tx_fire        = tx_axis_tvalid && tx_axis_tready;
    assign tx_last        = (tx_beat_q == beats_q - LEN_WIDTH'(1));
    assign rx_axis_tready = busy;
    assign rx_fire        = rx_axis_tvalid && rx_axis_tready;
    assign tx_axis_tuser  = '0;

    // Packet geometry derived from the requested length at start time.
    logic [LEN_WIDTH:0]    len_plus;
    logic [LEN_WIDTH-1:0]  beats_calc;
    logic [LEN_WIDTH-1:0]  len_rem;
    logic [KEEP_WIDTH-1:0] keep_calc;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        len_plus   = {1'b0, cfg_pkt_len} + (LEN_WIDTH+1)'(KEEP_WIDTH - 1);
        beats_calc = LEN_WIDTH'(len_plus / (LEN_WIDTH+1)'(KEEP_WIDTH));
        len_rem    = cfg_pkt_len % LEN_WIDTH'(KEEP_WIDTH);
        keep_calc  = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            keep_calc[k] = (len_rem == '0) || (LEN_WIDTH'(k) < len_rem);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) state_d = cfg_empty ? S_DONE : S_SEND;
            end
            S_SEND: begin
                if (tx_fire && tx_last && (tx_pkt_cnt == num_q - CNT_WIDTH'(1)))
                    state_d = S_TX_DONE;
            end
            S_TX_DONE: begin
                // >= rather than == so spurious early-tlast packets cannot stall the run.
                if (rx_pkt_cnt >= num_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Generator datapath: beat contents follow the packet/beat indices,
    // and are forced to zero whenever no beat is offered.
    // ------------------------------------------------------------------
    always_comb begin
        tx_axis_tdata = '0;
        tx_axis_tkeep = '0;
        tx_axis_tlast = 1'b0;
        if (tx_axis_tvalid) begin
            tx_axis_tdata = beat_data(tx_pkt_cnt[7:0], tx_beat_q);
            tx_axis_tkeep = tx_last ? last_keep_q : '1;
            tx_axis_tlast = tx_last;
        end
    end

    // ------------------------------------------------------------------
    // Checker: compare the received beat against the expected one.
    // ------------------------------------------------------------------
    logic                  rx_exp_last;
    logic                  rx_late;
    logic [KEEP_WIDTH-1:0] rx_exp_keep;
    logic [DATA_WIDTH-1:0] rx_exp_data;
    logic                  rx_data_bad;
    logic                  rx_beat_err;

    always_comb begin
        rx_exp_last = (rx_beat_q == beats_q - LEN_WIDTH'(1));
        rx_late     = (rx_beat_q >= beats_q);
        rx_exp_keep = rx_exp_last ? last_keep_q : '1;
        rx_exp_data = beat_data(rx_pkt_q, rx_beat_q);
        rx_data_bad = 1'b0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            if (rx_exp_keep[k] && (rx_axis_tdata[8*k +: 8] != rx_exp_data[8*k +: 8]))
                rx_data_bad = 1'b1;
        end
        // One flag per beat, however many individual faults it has.
        rx_beat_err = rx_late
                   || (rx_axis_tkeep != rx_exp_keep)
                   || rx_data_bad
                   || rx_axis_tuser[0]
                   || (rx_axis_tlast != rx_exp_last);
    end

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers are updated with <= so every process sees pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            beats_q     <= '0;
            last_keep_q <= '0;
            tx_beat_q   <= '0;
            rx_pkt_q    <= '0;
            rx_beat_q   <= '0;
            tx_pkt_cnt  <= '0;
            rx_pkt_cnt  <= '0;
            err_cnt     <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                num_q       <= cfg_pkt_num;
                beats_q     <= beats_calc;
                last_keep_q <= keep_calc;
                tx_beat_q   <= '0;
                rx_pkt_q    <= '0;
                rx_beat_q   <= '0;
                tx_pkt_cnt  <= '0;
                rx_pkt_cnt  <= '0;
                err_cnt     <= '0;
            end else begin
                if (tx_fire) begin
                    if (tx_last) begin
                        tx_beat_q  <= '0;
                        tx_pkt_cnt <= sat_inc(tx_pkt_cnt);
                    end else begin
                        tx_beat_q <= tx_beat_q + LEN_WIDTH'(1);
                    end
                end
                if (rx_fire) begin
                    if (rx_beat_err) err_cnt <= sat_inc(err_cnt);
                    // tlast always resynchronises to the next packet, errored or not.
                    if (rx_axis_tlast) begin
                        rx_pkt_cnt <= sat_inc(rx_pkt_cnt);
                        rx_pkt_q   <= rx_pkt_q + 8'd1;
                        rx_beat_q  <= '0;
                    end else if (rx_beat_q != '1) begin
                        rx_beat_q <= rx_beat_q + LEN_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_loopback_tester.sv
// -----------------------------------------------------------------------------
// tb_axis_loopback_tester
//
// Bench for axis_loopback_tester. TX is looped back to RX (optionally stalled
// or with one byte corrupted), or RX is driven directly by the bench. A
// behavioural model of the run tracks packets and beats and is compared with
// the DUT on every falling clock edge; hand-computed literals pin the model.
// -----------------------------------------------------------------------------
module tb_axis_loopback_tester;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int UW = 1;
    localparam int LW = 16;
    localparam int CW = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] cfg_pkt_num;
    logic [LW-1:0] cfg_pkt_len;
    logic          busy;
    logic          done;

    logic          tx_tvalid, tx_tready, tx_tlast;
    logic [DW-1:0] tx_tdata;
    logic [KW-1:0] tx_tkeep;
    logic [UW-1:0] tx_tuser;

    logic          rx_tvalid, rx_tready, rx_tlast;
    logic [DW-1:0] rx_tdata;
    logic [KW-1:0] rx_tkeep;
    logic [UW-1:0] rx_tuser;

    logic [CW-1:0] tx_pkt_cnt, rx_pkt_cnt, err_cnt;

    // Stream plumbing controls
    logic          ext_mode;      // 1: bench drives RX directly
    logic          rand_stall;    // 1: loopback link randomly stalls
    logic          gate;          // loopback link enable this cycle
    logic          corrupt_en;    // flip a byte of packet 1 on the wire
    logic [DW-1:0] corrupt_mask;
    logic          ext_tx_tready;
    logic          ext_rx_tvalid, ext_rx_tlast;
    logic [DW-1:0] ext_rx_tdata;
    logic [KW-1:0] ext_rx_tkeep;
    logic [UW-1:0] ext_rx_tuser;

    assign rx_tvalid = ext_mode ? ext_rx_tvalid : (tx_tvalid & gate);
    assign tx_tready = ext_mode ? ext_tx_tready : (rx_tready & gate);
    assign rx_tlast  = ext_mode ? ext_rx_tlast  : tx_tlast;
    assign rx_tkeep  = ext_mode ? ext_rx_tkeep  : tx_tkeep;
    assign rx_tuser  = ext_mode ? ext_rx_tuser  : tx_tuser;
    assign rx_tdata  = ext_mode ? ext_rx_tdata
                     : (tx_tdata ^ ((corrupt_en && tx_pkt_cnt == 1) ? corrupt_mask : '0));

    axis_loopback_tester #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_pkt_num    (cfg_pkt_num),
        .cfg_pkt_len    (cfg_pkt_len),
        .busy           (busy),
        .done           (done),
        .tx_axis_tvalid (tx_tvalid),
        .tx_axis_tready (tx_tready),
        .tx_axis_tlast  (tx_tlast),
        .tx_axis_tdata  (tx_tdata),
        .tx_axis_tkeep  (tx_tkeep),
        .tx_axis_tuser  (tx_tuser),
        .rx_axis_tvalid (rx_tvalid),
        .rx_axis_tready (rx_tready),
        .rx_axis_tlast  (rx_tlast),
        .rx_axis_tdata  (rx_tdata),
        .rx_axis_tkeep  (rx_tkeep),
        .rx_axis_tuser  (rx_tuser),
        .tx_pkt_cnt     (tx_pkt_cnt),
        .rx_pkt_cnt     (rx_pkt_cnt),
        .err_cnt        (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Payload rules written straight from the packet format
    // ------------------------------------------------------------------
    function automatic int n_beats(input int len);
        return (len + KW - 1) / KW;
    endfunction

    function automatic logic [KW-1:0] exp_keep(input int len, input int b);
        logic [KW-1:0] one;
        one = 1;
        if ((b == n_beats(len) - 1) && (len % KW != 0)) return (one << (len % KW)) - one;
        return '1;
    endfunction

    function automatic logic [DW-1:0] exp_data(input int p, input int b);
        logic [DW-1:0] d;
        for (int k = 0; k < KW; k++) d[8*k +: 8] = 8'((p + b * KW + k) % 256);
        return d;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model of a run and the per-cycle compare process.
    // Inputs change just after the rising edge, so at the falling edge the
    // upcoming handshakes are already decided and the model steps over them.
    // ------------------------------------------------------------------
    bit m_busy, m_done, m_tx_on, m_fin, m_e;
    int m_num, m_len;
    int m_tx_p, m_tx_b, m_tx_cnt;
    int m_rx_p, m_rx_b, m_rx_cnt, m_err;
    int m_nb;
    logic [KW-1:0] m_ek;
    logic [DW-1:0] m_ed;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_tx_on = 0;
            m_num = 0; m_len = 0;
            m_tx_p = 0; m_tx_b = 0; m_tx_cnt = 0;
            m_rx_p = 0; m_rx_b = 0; m_rx_cnt = 0; m_err = 0;
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_tvalid", tx_tvalid, 0);
            check("rst_rx_tready", rx_tready, 0);
            check("rst_tx_cnt", tx_pkt_cnt, 0);
        end else begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("tx_tvalid", tx_tvalid, m_tx_on);
            check("rx_tready", rx_tready, m_busy);
            check("tx_tuser", tx_tuser, 0);
            check("tx_pkt_cnt", tx_pkt_cnt, m_tx_cnt);
            check("rx_pkt_cnt", rx_pkt_cnt, m_rx_cnt);
            check("err_cnt", err_cnt, m_err);
            if (m_tx_on) begin
                m_nb = n_beats(m_len);
                check("tx_tdata", tx_tdata, exp_data(m_tx_p, m_tx_b));
                check("tx_tkeep", tx_tkeep, exp_keep(m_len, m_tx_b));
                check("tx_tlast", tx_tlast, m_tx_b == m_nb - 1);
            end

            // Advance the model across the coming rising edge.
            m_fin = m_busy && !m_tx_on && (m_rx_cnt >= m_num);
            if (start && !m_busy) begin
                m_num = int'(cfg_pkt_num);
                m_len = int'(cfg_pkt_len);
                m_busy = (m_num != 0) && (m_len != 0);
                m_done = !m_busy;
                m_tx_on = m_busy;
                m_tx_p = 0; m_tx_b = 0; m_tx_cnt = 0;
                m_rx_p = 0; m_rx_b = 0; m_rx_cnt = 0; m_err = 0;
            end else if (m_busy) begin
                m_nb = n_beats(m_len);
                if (m_tx_on && tx_tready) begin
                    if (m_tx_b == m_nb - 1) begin
                        m_tx_b = 0;
                        m_tx_p++;
                        m_tx_cnt++;
                        if (m_tx_p == m_num) m_tx_on = 0;
                    end else begin
                        m_tx_b++;
                    end
                end
                if (rx_tvalid) begin
                    m_e = 0;
                    if (m_rx_b >= m_nb) begin
                        m_e = 1;
                    end else begin
                        m_ek = exp_keep(m_len, m_rx_b);
                        m_ed = exp_data(m_rx_p, m_rx_b);
                        if (rx_tkeep != m_ek) m_e = 1;
                        for (int k = 0; k < KW; k++)
                            if (m_ek[k] && rx_tdata[8*k +: 8] != m_ed[8*k +: 8]) m_e = 1;
                    end
                    if (rx_tuser[0]) m_e = 1;
                    if (rx_tlast != (m_rx_b == m_nb - 1)) m_e = 1;
                    if (m_e) m_err++;
                    if (rx_tlast) begin
                        m_rx_cnt++;
                        m_rx_p++;
                        m_rx_b = 0;
                    end else begin
                        m_rx_b++;
                    end
                end
                if (m_fin) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
    end

    // Loopback link enable, refreshed just after every rising edge.
    initial begin
        gate = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            gate = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic do_start(input int num, input int len);
        @(posedge clk);
        #1;
        cfg_pkt_num = CW'(num);
        cfg_pkt_len = LW'(len);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("done_within_budget", done, 1);
    endtask

    task automatic rx_send(input int p, input int b, input bit last, input bit user);
        ext_rx_tdata  = exp_data(p, b);
        ext_rx_tkeep  = '1;
        ext_rx_tlast  = last;
        ext_rx_tuser  = UW'(user);
        ext_rx_tvalid = 1'b1;
        @(posedge clk);
        #1;
        ext_rx_tvalid = 1'b0;
        ext_rx_tlast  = 1'b0;
        ext_rx_tuser  = '0;
    endtask

    task automatic check_counts(input string tag, input int tx, input int rx, input int er);
        check({tag, "_tx_cnt"}, tx_pkt_cnt, tx);
        check({tag, "_rx_cnt"}, rx_pkt_cnt, rx);
        check({tag, "_err_cnt"}, err_cnt, er);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int i;
        rst_n = 1'b0;
        start = 1'b0;
        cfg_pkt_num = '0;
        cfg_pkt_len = '0;
        ext_mode = 1'b0;
        rand_stall = 1'b0;
        corrupt_en = 1'b0;
        corrupt_mask = '0;
        corrupt_mask[47:40] = 8'hFF;
        ext_tx_tready = 1'b0;
        ext_rx_tvalid = 1'b0;
        ext_rx_tlast = 1'b0;
        ext_rx_tdata = '0;
        ext_rx_tkeep = '0;
        ext_rx_tuser = '0;

        #12;
        check("reset_tdata", tx_tdata, 0);
        check("reset_tkeep", tx_tkeep, 0);
        check("reset_tlast", tx_tlast, 0);
        check("reset_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: one single-beat packet, bytes 0x00..0x3F.
        do_start(1, 64);
        check("t1_tvalid", tx_tvalid, 1);
        check("t1_byte0", tx_tdata[7:0], 8'h00);
        check("t1_byte63", tx_tdata[511:504], 8'h3F);
        check("t1_tkeep", tx_tkeep, {KW{1'b1}});
        check("t1_tlast", tx_tlast, 1);
        wait_done(50);
        check_counts("t1", 1, 1, 0);

        // 2: three 2-beat packets, last beat keeps 36 bytes.
        do_start(3, 100);
        i = 0;
        while (!(tx_tvalid && tx_tlast && tx_pkt_cnt == 0) && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("t2_last_tkeep", tx_tkeep, 64'h0000_000F_FFFF_FFFF);
        i = 0;
        while (!(tx_tvalid && tx_pkt_cnt == 2) && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("t2_pkt2_byte0", tx_tdata[7:0], 8'h02);
        wait_done(50);
        check_counts("t2", 3, 3, 0);

        // 3: 300 three-beat packets over a randomly stalling link.
        rand_stall = 1'b1;
        do_start(300, 130);
        i = 0;
        while (!(tx_tvalid && tx_pkt_cnt == 257) && i < 5000) begin
            @(negedge clk);
            i++;
        end
        check("t3_pkt257_byte0", tx_tdata[7:0], 8'h01);
        check("t3_pkt257_byte63", tx_tdata[511:504], 8'h40);
        wait_done(5000);
        rand_stall = 1'b0;
        check_counts("t3", 300, 300, 0);

        // 4: one byte of packet 1 flipped on the wire.
        corrupt_en = 1'b1;
        do_start(2, 64);
        wait_done(50);
        corrupt_en = 1'b0;
        check_counts("t4", 2, 2, 1);

        // 5: checker driven directly; early tlast, then a tuser-flagged beat.
        ext_mode = 1'b1;
        ext_tx_tready = 1'b0;
        do_start(2, 128);
        rx_send(0, 0, 1'b1, 1'b0);
        rx_send(1, 0, 1'b0, 1'b1);
        rx_send(1, 1, 1'b1, 1'b0);
        ext_tx_tready = 1'b1;
        wait_done(50);
        check_counts("t5", 2, 2, 2);
        ext_mode = 1'b0;
        ext_tx_tready = 1'b0;

        // 6: zero-count start, then reset in the middle of a run.
        do_start(0, 64);
        check("t6_zero_done", done, 1);
        check("t6_zero_busy", busy, 0);
        check("t6_zero_tvalid", tx_tvalid, 0);
        do_start(5, 200);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_tvalid", tx_tvalid, 0);
        check("t6_rst_tlast", tx_tlast, 0);
        check("t6_rst_tdata", tx_tdata, 0);
        check("t6_rst_tkeep", tx_tkeep, 0);
        check("t6_rst_rx_tready", rx_tready, 0);
        check("t6_rst_tx_cnt", tx_pkt_cnt, 0);
        check("t6_rst_rx_cnt", rx_pkt_cnt, 0);
        check("t6_rst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_start(2, 70);
        wait_done(50);
        check_counts("t6", 2, 2, 0);

        repeat (3) @(negedge clk);
        finish_run();
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        finish_run();
    end

endmodule
